// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu : multi-cycle execute-stage ALU with valid/ready handshakes.
//   Single-cycle add/sub/logic/compare; shifts are iterative (one bit per
//   cycle) unless SEQ_ALU_BARREL_SHIFT_EN is defined, which selects a
//   single-cycle barrel shifter instead.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] comb_result;
  logic             comb_illegal;

  // Only the low SHW bits of operand B matter for shifts.
  assign shamt = src_b[SHW-1:0];

  // Flag is derived from the held result; meaningful only while out_valid.
  assign zero = (result == '0);

`ifndef SEQ_ALU_BARREL_SHIFT_EN
  logic [SHW-1:0]   count;
  logic [1:0]       shift_op;   // alu_control[1:0]: 01 SLL, 10 SRL, 11 SRA
  logic             start_shift;
  logic [WIDTH-1:0] shift_next;

  // One-bit shift step applied to the working register each SHIFT cycle.
  always_comb begin
    shift_next = result;
    case (shift_op)
      2'b01:   shift_next = {result[WIDTH-2:0], 1'b0};
      2'b10:   shift_next = {1'b0, result[WIDTH-1:1]};
      default: shift_next = {result[WIDTH-1], result[WIDTH-1:1]};
    endcase
  end
`endif

  // Single-cycle datapath: result and legality of the presented request.
  always_comb begin
    comb_result  = '0;
    comb_illegal = 1'b0;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
    start_shift  = 1'b0;
`endif
    case (alu_control)
      4'b0000: comb_result = src_a + src_b;
      4'b0001: comb_result = src_a - src_b;
      4'b0010: comb_result = src_a ^ src_b;
      4'b0011: comb_result = src_a | src_b;
      4'b0100: comb_result = src_a & src_b;
      4'b0101, 4'b0110, 4'b0111: begin
`ifdef SEQ_ALU_BARREL_SHIFT_EN
        case (alu_control[1:0])
          2'b01:   comb_result = src_a << shamt;
          2'b10:   comb_result = src_a >> shamt;
          default: comb_result = $unsigned($signed(src_a) >>> shamt);
        endcase
`else
        // Zero shift amount finishes immediately with the source unchanged.
        comb_result = src_a;
        start_shift = (shamt != '0);
`endif
      end
      4'b1000: comb_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b1001: comb_result = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      default: comb_illegal = 1'b1;
    endcase
  end

  // Control FSM with registered handshake/status outputs and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
      count     <= '0;
      shift_op  <= 2'b00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            result   <= comb_result;
            illegal  <= comb_illegal;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
            if (start_shift) begin
              state    <= SHIFT;
              count    <= shamt;
              shift_op <= alu_control[1:0];
            end else
`endif
            begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
`ifndef SEQ_ALU_BARREL_SHIFT_EN
        SHIFT: begin
          result <= shift_next;
          count  <= count - 1'b1;
          if (count == SHW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu : directed self-checking bench for seq_alu (WIDTH=32).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_alu;

  localparam int WIDTH = 32;
`ifdef SEQ_ALU_BARREL_SHIFT_EN
  localparam int LAT_SH4  = 1;
  localparam int LAT_SH31 = 1;
  localparam int LAT_SH20 = 1;
`else
  localparam int LAT_SH4  = 5;
  localparam int LAT_SH31 = 32;
  localparam int LAT_SH20 = 21;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for one cycle, then count cycles until out_valid
  // (1 = visible in the cycle right after the handshake). Caps at 100.
  task automatic issue(input logic [3:0] code, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    alu_control = code;
    src_a       = a;
    src_b       = b;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Accept the held result for one cycle.
  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid, zero, illegal, busy} !== 5'b10100) begin
      failures++;
      $display("FAIL reset_flags: got rdy/vld/zero/ill/busy=%b required 10100",
               {in_ready, out_valid, zero, illegal, busy});
    end
    checks++;
    if (result !== 32'h0) begin
      failures++;
      $display("FAIL reset_result: got %h required 00000000", result);
    end
  endtask

  task automatic test_arith();
    int lat;
    issue(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    checks++;
    if (lat !== 1 || result !== 32'h8000_0000 || zero !== 1'b0) begin
      failures++;
      $display("FAIL add_wrap: got lat=%0d res=%h zero=%b required lat=1 res=80000000 zero=0",
               lat, result, zero);
    end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_status: got busy=%b in_ready=%b required busy=1 in_ready=0",
               busy, in_ready);
    end
    release_result();
    issue(4'b0001, 32'd5, 32'd5, lat);
    checks++;
    if (lat !== 1 || result !== 32'h0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL sub_zero: got lat=%0d res=%h zero=%b required lat=1 res=00000000 zero=1",
               lat, result, zero);
    end
    release_result();
  endtask

  task automatic test_logic();
    int lat;
    logic [31:0] exp_res [3];
    logic [3:0]  codes   [3];
    exp_res = '{32'h0000_0FF0, 32'h0000_FFF0, 32'h0000_F000};
    codes   = '{4'b0010, 4'b0011, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      issue(codes[i], 32'h0000_F0F0, 32'h0000_FF00, lat);
      checks++;
      if (lat !== 1 || result !== exp_res[i]) begin
        failures++;
        $display("FAIL logic_op%0d: got lat=%0d res=%h required lat=1 res=%h",
                 i, lat, result, exp_res[i]);
      end
      release_result();
    end
  endtask

  task automatic test_compare();
    int lat;
    issue(4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    checks++;
    if (lat !== 1 || result !== 32'h1) begin
      failures++;
      $display("FAIL slt: got lat=%0d res=%h required lat=1 res=00000001", lat, result);
    end
    release_result();
    issue(4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    checks++;
    if (lat !== 1 || result !== 32'h0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL sltu: got lat=%0d res=%h zero=%b required lat=1 res=00000000 zero=1",
               lat, result, zero);
    end
    release_result();
  endtask

  task automatic test_shift();
    int lat;
    issue(4'b0111, 32'h8000_0000, 32'h0000_0004, lat);
    checks++;
    if (lat !== LAT_SH4 || result !== 32'hF800_0000) begin
      failures++;
      $display("FAIL sra: got lat=%0d res=%h required lat=%0d res=f8000000",
               lat, result, LAT_SH4);
    end
    release_result();
    issue(4'b0110, 32'h8000_0000, 32'h0000_0004, lat);
    checks++;
    if (lat !== LAT_SH4 || result !== 32'h0800_0000) begin
      failures++;
      $display("FAIL srl: got lat=%0d res=%h required lat=%0d res=08000000",
               lat, result, LAT_SH4);
    end
    release_result();
    issue(4'b0101, 32'h0000_0001, 32'h0000_001F, lat);
    checks++;
    if (lat !== LAT_SH31 || result !== 32'h8000_0000) begin
      failures++;
      $display("FAIL sll31: got lat=%0d res=%h required lat=%0d res=80000000",
               lat, result, LAT_SH31);
    end
    release_result();
    // Amount bits above the shift field are ignored: 0x20 means shift by 0.
    issue(4'b0101, 32'h1234_5678, 32'h0000_0020, lat);
    checks++;
    if (lat !== 1 || result !== 32'h1234_5678) begin
      failures++;
      $display("FAIL shamt0: got lat=%0d res=%h required lat=1 res=12345678", lat, result);
    end
    release_result();
  endtask

  task automatic test_illegal();
    int lat;
    issue(4'b1111, 32'hDEAD_BEEF, 32'h1, lat);
    checks++;
    if (lat !== 1 || illegal !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL illegal: got lat=%0d ill=%b res=%h zero=%b required lat=1 ill=1 res=0 zero=1",
               lat, illegal, result, zero);
    end
    release_result();
    issue(4'b0000, 32'd2, 32'd3, lat);
    checks++;
    if (illegal !== 1'b0 || result !== 32'd5) begin
      failures++;
      $display("FAIL illegal_clear: got ill=%b res=%h required ill=0 res=00000005",
               illegal, result);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    issue(4'b0000, 32'd1, 32'd1, lat);
    // Present a competing XOR request while the result is held.
    alu_control = 4'b0010;
    src_a       = 32'h0000_00A5;
    src_b       = 32'h0000_000F;
    in_valid    = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 32'd2 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable: got %0d bad cycles (last vld=%b res=%h rdy=%b) required 0",
               bad, out_valid, result, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_idle: got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h0000_00AA) begin
      failures++;
      $display("FAIL queued_op: got vld=%b res=%h required vld=1 res=000000aa", out_valid, result);
    end
    release_result();
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    alu_control = 4'b0101;
    src_a       = 32'h0000_0001;
    src_b       = 32'd20;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_shift: got busy=%b vld=%b required busy=1 vld=0", busy, out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset: got vld=%b res=%h rdy=%b busy=%b required 0 00000000 1 0",
               out_valid, result, in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(4'b0101, 32'h0000_0001, 32'd20, lat);
    checks++;
    if (lat !== LAT_SH20 || result !== 32'h0010_0000) begin
      failures++;
      $display("FAIL post_reset_op: got lat=%0d res=%h required lat=%0d res=00100000",
               lat, result, LAT_SH20);
    end
    release_result();
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_control = 4'b0000;
    src_a       = '0;
    src_b       = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_arith();
    test_logic();
    test_compare();
    test_shift();
    test_illegal();
    test_back_to_back();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle execution unit; the consumer of the 4-bit alu_control code produced by the ALU decoder.
- Executes one operation per handshake on two WIDTH-bit operands.
- Single-cycle path for add/sub/logic/compare ops; iterative one-bit-per-cycle shifter for SLL/SRL/SRA.
- Sits in the execute stage of the multi-cycle core, between operand muxing and writeback, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand/result width; must be a power of 2, >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- alu_control  in  4  operation code, sampled on input handshake.
- src_a  in  WIDTH  operand A / shift source, sampled on input handshake.
- src_b  in  WIDTH  operand B; bits [SHW-1:0] are the shift amount for shifts.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- illegal  out  1  alu_control was not a defined code.
- busy  out  1  state != IDLE.

Behaviour:
- Codes: 0000 ADD, 0001 SUB, 0010 XOR, 0011 OR, 0100 AND, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT (signed), 1001 SLTU. 1010-1111 are illegal.
- Reset (async, rst_n low): state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, illegal=0, busy=0, shift count=0. Reset mid-SHIFT or mid-DONE aborts the operation; no result is produced.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1.
  - Input handshake (in_valid & in_ready): capture operands and code.
  - Non-shift, legal: result computed, go DONE. out_valid rises the cycle after the handshake (latency 1).
  - Illegal code: result=0, illegal=1, go DONE (latency 1).
  - Shift with shamt = src_b[SHW-1:0] == 0: result=src_a, go DONE (latency 1).
  - Shift with shamt > 0: load src_a into the shift register, count=shamt, go SHIFT.
- SHIFT: each cycle shift by one bit and decrement count.
  - SLL fills 0 at the LSB. SRL fills 0 at the MSB. SRA replicates the MSB.
  - When count reaches 0, go DONE. out_valid rises shamt+1 cycles after the handshake.
  - Operand bits above SHW are ignored.
- DONE: out_valid=1; result, zero and illegal are held stable until out_ready.
  - On out_valid & out_ready: go IDLE, out_valid=0 next cycle.
  - No new request is accepted in the same cycle (in_ready=0 in DONE). Maximum throughput is 1 op per 2 cycles.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
  - SLT/SLTU produce a zero-extended 0/1.
- zero is combinational from the registered result and valid only while out_valid=1.
- in_valid while not in IDLE: ignored; the requester must hold the request until in_ready.
- Inputs are don't-care when in_valid=0.

Optional Feature:
- Macro: SEQ_ALU_BARREL_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter. SHIFT state is never entered, and every legal or illegal op has latency 1.
- Undefined: iterative shifter as above, latency shamt+1 for shamt > 0.
- Handshake, codes, reset values and flags are identical in both builds.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, zero=0, out_valid 1 cycle after accept. SUB 5-5 -> result 0, zero=1.
- SRA src_a=0x80000000, src_b=4 -> result 0xF8000000 after 5 cycles (1 with macro). SRL same operands -> 0x08000000. SLL 0x1 by 31 -> 0x80000000 after 32 cycles.
- SLT 0xFFFFFFFF vs 0x00000001 -> 1; SLTU same operands -> 0. Shift with src_b=0x00000020 (shamt 0) -> result = src_a, latency 1.
- alu_control=1111 -> illegal=1, result=0, zero=1; next legal op clears illegal.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0, a new in_valid is not accepted; release -> IDLE, then the new op is accepted.
- Assert rst_n low during SHIFT of SLL by 20 -> immediate IDLE, out_valid=0, result=0; the first op after reset completes normally.
